// File: rtl/subleq_core.sv
// +--------------------------------------------------------------------------+
// | Module      : subleq_core                                                |
// | Description : Single-master SUBLEQ execution engine. Fetches A, B, C at  |
// |               pc..pc+2, reads mem[A] and mem[B], writes mem[B]-mem[A]    |
// |               back to B and branches to C when the result is <= 0.       |
// |               Every bus transaction is request / ready-or-done / one     |
// |               idle cycle, with a bounded wait that raises bus_error.     |
// | Ports       : clk       - system clock, rising edge                      |
// |               rst_n     - asynchronous active-low reset                  |
// |               data      - shared data bus, driven only during writes     |
// |               addr      - bus address, holds last value when idle        |
// |               ctrl      - drives RD_REQ / WR_REQ, samples RD_READY /     |
// |                           WR_DONE, all other bits released (z)           |
// |               pc        - address of the current instruction             |
// |               halted    - sticky, taken branch to HALT_ADDR              |
// |               bus_error - sticky, request timeout                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 4
`endif

module subleq_core #(
   parameter int                   DATAWIDTH     = `DATAWIDTH,
   parameter int                   CTRLWIDTH     = `CTRLWIDTH,
   parameter logic [DATAWIDTH-1:0] RESET_PC      = '0,
   parameter logic [DATAWIDTH-1:0] HALT_ADDR     = {DATAWIDTH{1'b1}},
   parameter int                   TIMEOUT       = 16,
   parameter int                   CTRL_RD_REQ   = 0,
   parameter int                   CTRL_WR_REQ   = 1,
   parameter int                   CTRL_RD_READY = 2,
   parameter int                   CTRL_WR_DONE  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   inout  wire  [DATAWIDTH-1:0] data,
   output logic [DATAWIDTH-1:0] addr,
   inout  wire  [CTRLWIDTH-1:0] ctrl,
   output logic [DATAWIDTH-1:0] pc,
   output logic                 halted,
   output logic                 bus_error
);

   // Request-cycle counter only has to reach TIMEOUT-1.
   localparam int C_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH_A = 4'd0,
      S_FETCH_B = 4'd1,
      S_FETCH_C = 4'd2,
      S_READ_A  = 4'd3,
      S_READ_B  = 4'd4,
      S_WRITE_B = 4'd5,
      S_BRANCH  = 4'd6,
      S_HALT    = 4'd7,
      S_ERROR   = 4'd8
   } state_t;

   // Sub-phase of a transaction state. PH_ISSUE is only used straight out of
   // reset; afterwards each idle cycle launches the following transaction.
   typedef enum logic [1:0] {
      PH_ISSUE = 2'd0,
      PH_REQ   = 2'd1,
      PH_IDLE  = 2'd2
   } phase_t;

   state_t                 r_state;
   phase_t                 r_phase;
   logic [C_CNT_W-1:0]     r_cnt;
   logic [DATAWIDTH-1:0]   r_pc;
   logic [DATAWIDTH-1:0]   r_addr;
   logic [DATAWIDTH-1:0]   r_a;
   logic [DATAWIDTH-1:0]   r_b;
   logic [DATAWIDTH-1:0]   r_c;
   logic [DATAWIDTH-1:0]   r_va;
   logic [DATAWIDTH-1:0]   r_vb;
   logic                   r_rd_req;
   logic                   r_wr_req;
   logic                   r_halted;
   logic                   r_bus_error;

   logic [DATAWIDTH-1:0]   w_result;
   logic                   w_taken;
   logic [DATAWIDTH-1:0]   w_branch_pc;
   state_t                 w_next_state;
   logic                   w_ack;
   logic                   w_ctrl_unused;

   // Bus address for the transaction belonging to a given state.
   function automatic logic [DATAWIDTH-1:0] f_tx_addr(
      input state_t               s,
      input logic [DATAWIDTH-1:0] pc_v,
      input logic [DATAWIDTH-1:0] a_v,
      input logic [DATAWIDTH-1:0] b_v
   );
      case (s)
         S_FETCH_A:           f_tx_addr = pc_v;
         S_FETCH_B:           f_tx_addr = pc_v + DATAWIDTH'(1);
         S_FETCH_C:           f_tx_addr = pc_v + DATAWIDTH'(2);
         S_READ_A:            f_tx_addr = a_v;
         S_READ_B, S_WRITE_B: f_tx_addr = b_v;
         default:             f_tx_addr = pc_v;
      endcase
   endfunction

   always_comb begin
      w_result     = r_vb - r_va;
      w_taken      = (w_result == '0) || w_result[DATAWIDTH-1];
      w_branch_pc  = w_taken ? r_c : (r_pc + DATAWIDTH'(3));
      w_ack        = r_wr_req ? ctrl[CTRL_WR_DONE] : ctrl[CTRL_RD_READY];
      w_next_state = r_state;
      case (r_state)
         S_FETCH_A: w_next_state = S_FETCH_B;
         S_FETCH_B: w_next_state = S_FETCH_C;
         S_FETCH_C: w_next_state = S_READ_A;
         S_READ_A:  w_next_state = S_READ_B;
         S_READ_B:  w_next_state = S_WRITE_B;
         S_WRITE_B: w_next_state = S_BRANCH;
         S_BRANCH:  w_next_state = S_FETCH_A;
         default:   w_next_state = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH_A;
         r_phase     <= PH_ISSUE;
         r_cnt       <= '0;
         r_pc        <= RESET_PC;
         r_addr      <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_va        <= '0;
         r_vb        <= '0;
         r_rd_req    <= 1'b0;
         r_wr_req    <= 1'b0;
         r_halted    <= 1'b0;
         r_bus_error <= 1'b0;
      end else begin
         case (r_state)
            S_HALT, S_ERROR: begin
               // Terminal: everything holds until reset.
            end

            S_BRANCH: begin
               if (w_taken && (r_c == HALT_ADDR)) begin
                  r_pc     <= r_c;
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  // The next fetch is launched on the same edge that
                  // updates pc, keeping one instruction at 19 cycles.
                  r_pc     <= w_branch_pc;
                  r_state  <= S_FETCH_A;
                  r_addr   <= w_branch_pc;
                  r_rd_req <= 1'b1;
                  r_cnt    <= '0;
                  r_phase  <= PH_REQ;
               end
            end

            default: begin
               case (r_phase)
                  PH_ISSUE: begin
                     r_addr  <= f_tx_addr(r_state, r_pc, r_a, r_b);
                     r_cnt   <= '0;
                     r_phase <= PH_REQ;
                     if (r_state == S_WRITE_B) begin
                        r_wr_req <= 1'b1;
                     end else begin
                        r_rd_req <= 1'b1;
                     end
                  end

                  PH_REQ: begin
                     // Responders register their flag one edge after the
                     // request, so the flag seen in req cycle 0 is stale.
                     if ((r_cnt != '0) && w_ack) begin
                        case (r_state)
                           S_FETCH_A: r_a  <= data;
                           S_FETCH_B: r_b  <= data;
                           S_FETCH_C: r_c  <= data;
                           S_READ_A:  r_va <= data;
                           S_READ_B:  r_vb <= data;
                           default:   ;
                        endcase
                        r_rd_req <= 1'b0;
                        r_wr_req <= 1'b0;
                        r_phase  <= PH_IDLE;
                     end else if (r_cnt == C_CNT_LAST) begin
                        r_rd_req    <= 1'b0;
                        r_wr_req    <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_state     <= S_ERROR;
                     end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                     end
                  end

                  PH_IDLE: begin
                     r_state <= w_next_state;
                     if (w_next_state == S_BRANCH) begin
                        r_phase <= PH_ISSUE;
                     end else begin
                        r_addr  <= f_tx_addr(w_next_state, r_pc, r_a, r_b);
                        r_cnt   <= '0;
                        r_phase <= PH_REQ;
                        if (w_next_state == S_WRITE_B) begin
                           r_wr_req <= 1'b1;
                        end else begin
                           r_rd_req <= 1'b1;
                        end
                     end
                  end

                  default: r_phase <= PH_ISSUE;
               endcase
            end
         endcase
      end
   end

   // Write data is taken straight from VB-VA, which is stable for the whole
   // write transaction.
   assign data = r_wr_req ? w_result : {DATAWIDTH{1'bz}};

   generate
      for (genvar i = 0; i < CTRLWIDTH; i++) begin : g_ctrl
         if (i == CTRL_RD_REQ) begin : g_rd_req
            assign ctrl[i] = r_rd_req;
         end else if (i == CTRL_WR_REQ) begin : g_wr_req
            assign ctrl[i] = r_wr_req;
         end else begin : g_release
            assign ctrl[i] = 1'bz;
         end
      end
   endgenerate

   // Only the ready/done bits of ctrl are consumed.
   assign w_ctrl_unused = ^ctrl;

   assign addr      = r_addr;
   assign pc        = r_pc;
   assign halted    = r_halted;
   assign bus_error = r_bus_error;

endmodule

`default_nettype wire

// File: tb/tb_subleq_core.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_subleq_core                                             |
// | Description : Directed bench for subleq_core with a RAM card responding  |
// |               below 0x8000 (ready/done registered one edge after the     |
// |               request) and pull-ups on the data bus.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_subleq_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   wire  [15:0] data;
   wire  [3:0]  ctrl;
   logic [15:0] addr;
   logic [15:0] pc;
   logic        halted;
   logic        bus_error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   subleq_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .addr      (addr),
      .ctrl      (ctrl),
      .pc        (pc),
      .halted    (halted),
      .bus_error (bus_error)
   );

   wire rd_req = ctrl[0];
   wire wr_req = ctrl[1];

   // RAM card model.
   logic [15:0] mem [0:32767];
   logic        ram_rd_ready = 1'b0;
   logic        ram_wr_done  = 1'b0;
   logic [15:0] ram_rdata    = '0;
   logic        ld_clr  = 1'b0;
   logic        ld_we   = 1'b0;
   logic [15:0] ld_addr = '0;
   logic [15:0] ld_data = '0;

   assign ctrl[2] = ram_rd_ready;
   assign ctrl[3] = ram_wr_done;
   assign data    = ram_rd_ready ? ram_rdata : 16'hzzzz;

   for (genvar i = 0; i < 16; i++) begin : g_pullup
      pullup pu (data[i]);
   end

   always @(posedge clk) begin
      ram_rd_ready <= 1'b0;
      ram_wr_done  <= 1'b0;
      if (ld_clr) begin
         for (int i = 0; i < 32768; i++) mem[i] <= '0;
      end else if (ld_we) begin
         mem[ld_addr[14:0]] <= ld_data;
      end else begin
         if (rd_req && !ram_rd_ready && !addr[15]) begin
            ram_rd_ready <= 1'b1;
            ram_rdata    <= mem[addr[14:0]];
         end
         if (wr_req && !ram_wr_done && !addr[15]) begin
            ram_wr_done        <= 1'b1;
            mem[addr[14:0]]    <= data;
         end
      end
   end

   // Request log: {is_write, addr} for every rising request.
   logic [16:0] log_q [0:15];
   int          log_n = 0;
   logic        log_clr = 1'b0;
   logic        prev_rd = 1'b0;
   logic        prev_wr = 1'b0;

   always @(posedge clk) begin
      prev_rd <= rd_req;
      prev_wr <= wr_req;
      if (log_clr) begin
         log_n <= 0;
      end else if ((rd_req && !prev_rd) || (wr_req && !prev_wr)) begin
         if (log_n < 16) log_q[log_n[3:0]] <= {wr_req, addr};
         log_n <= log_n + 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic prep();
      rst_n   = 1'b0;
      ld_clr  = 1'b1;
      log_clr = 1'b1;
      @(posedge clk); #1;
      ld_clr  = 1'b0;
      log_clr = 1'b0;
   endtask

   task automatic load_word(input logic [15:0] a, input logic [15:0] d);
      ld_addr = a;
      ld_data = d;
      ld_we   = 1'b1;
      @(posedge clk); #1;
      ld_we   = 1'b0;
   endtask

   task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2);
      load_word(16'd0, w0);
      load_word(16'd1, w1);
      load_word(16'd2, w2);
   endtask

   // Releases reset mid-cycle and returns 1#after the edge that raised the
   // first request (E0+1), ok=0 if none within 10 cycles.
   task automatic release_and_sync(output bit ok);
      ok = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (rd_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      prep();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
      checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b want 0", wr_req); end
      checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", addr); end
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
      checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL reset_data_released: got %h want ffff (pulled up)", data); end
   endtask

   task automatic test_taken();
      bit ok;
      logic [16:0] exp_log [0:5];
      exp_log[0] = {1'b0, 16'd0};
      exp_log[1] = {1'b0, 16'd1};
      exp_log[2] = {1'b0, 16'd2};
      exp_log[3] = {1'b0, 16'd10};
      exp_log[4] = {1'b0, 16'd11};
      exp_log[5] = {1'b1, 16'd11};
      prep();
      load_prog(16'd10, 16'd11, 16'd20);
      load_word(16'd10, 16'd5);
      load_word(16'd11, 16'd3);
      release_and_sync(ok);
      checks++; if (!ok) begin errors++; $display("FAIL taken_first_request: got none want request within 10 cycles"); end
      checks++; if (addr !== 16'd0) begin errors++; $display("FAIL taken_first_addr: got %h want 0000", addr); end
      repeat (18) @(posedge clk);
      #1;
      checks++; if (pc !== 16'd0) begin errors++; $display("FAIL taken_pc_early: got %0d want 0 at cycle 18", pc); end
      @(posedge clk); #1;
      checks++; if (pc !== 16'd20) begin errors++; $display("FAIL taken_pc: got %0d want 20 at cycle 19", pc); end
      checks++; if (mem[11] !== 16'hFFFE) begin errors++; $display("FAIL taken_mem11: got %h want fffe", mem[11]); end
      checks++; if (log_n < 6) begin errors++; $display("FAIL taken_req_count: got %0d want >= 6", log_n); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (log_q[i] !== exp_log[i]) begin
            errors++;
            $display("FAIL taken_req_order[%0d]: got wr=%b addr=%0d want wr=%b addr=%0d",
                     i, log_q[i][16], log_q[i][15:0], exp_log[i][16], exp_log[i][15:0]);
         end
      end
   endtask

   task automatic test_not_taken();
      bit ok;
      prep();
      load_prog(16'd10, 16'd11, 16'd20);
      load_word(16'd10, 16'd2);
      load_word(16'd11, 16'd7);
      release_and_sync(ok);
      checks++; if (!ok) begin errors++; $display("FAIL nt_first_request: got none want request within 10 cycles"); end
      repeat (19) @(posedge clk);
      #1;
      checks++; if (pc !== 16'd3) begin errors++; $display("FAIL nt_pc: got %0d want 3", pc); end
      checks++; if (mem[11] !== 16'd5) begin errors++; $display("FAIL nt_mem11: got %h want 0005", mem[11]); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nt_halted: got %b want 0", halted); end
   endtask

   task automatic test_self_clear();
      bit ok;
      prep();
      load_prog(16'd12, 16'd12, 16'd30);
      load_word(16'd12, 16'h1234);
      release_and_sync(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sc_first_request: got none want request within 10 cycles"); end
      repeat (19) @(posedge clk);
      #1;
      checks++; if (pc !== 16'd30) begin errors++; $display("FAIL sc_pc: got %0d want 30", pc); end
      checks++; if (mem[12] !== 16'h0000) begin errors++; $display("FAIL sc_mem12: got %h want 0000", mem[12]); end
   endtask

   task automatic test_halt();
      bit ok;
      int busy;
      prep();
      load_prog(16'd10, 16'd11, 16'hFFFF);
      load_word(16'd10, 16'd1);
      load_word(16'd11, 16'd1);
      release_and_sync(ok);
      checks++; if (!ok) begin errors++; $display("FAIL halt_first_request: got none want request within 10 cycles"); end
      repeat (19) @(posedge clk);
      #1;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
      checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL halt_pc: got %h want ffff", pc); end
      busy = 0;
      for (int i = 0; i < 100; i++) begin
         if (rd_req || wr_req) busy++;
         @(posedge clk); #1;
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL halt_quiet: got %0d request cycles want 0", busy); end
      checks++; if (halted !== 1'b1 || pc !== 16'hFFFF) begin errors++; $display("FAIL halt_hold: got halted=%b pc=%h want 1 ffff", halted, pc); end
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL halt_bus_error: got %b want 0", bus_error); end
   endtask

   task automatic test_timeout();
      bit ok;
      int hi;
      int busy;
      prep();
      load_prog(16'h8000, 16'd11, 16'd20);
      release_and_sync(ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_first_request: got none want request within 10 cycles"); end
      repeat (9) @(posedge clk);
      #1;
      checks++; if (rd_req !== 1'b1 || addr !== 16'h8000) begin errors++; $display("FAIL to_read_a_issue: got rd=%b addr=%h want 1 8000", rd_req, addr); end
      hi = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (rd_req) hi++;
         else break;
      end
      checks++; if (hi != 16) begin errors++; $display("FAIL to_req_cycles: got %0d want 16", hi); end
      checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL to_bus_error: got %b want 1", bus_error); end
      checks++; if (pc !== 16'd0) begin errors++; $display("FAIL to_pc: got %h want 0000", pc); end
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (rd_req || wr_req) busy++;
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL to_quiet: got %0d request cycles want 0", busy); end
   endtask

   task automatic test_reset_mid_write();
      bit ok;
      prep();
      load_prog(16'd10, 16'd11, 16'd20);
      load_word(16'd10, 16'd2);
      load_word(16'd11, 16'd7);
      release_and_sync(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmw_first_request: got none want request within 10 cycles"); end
      repeat (15) @(posedge clk);
      #1;
      checks++; if (wr_req !== 1'b1 || addr !== 16'd11) begin errors++; $display("FAIL rmw_write_issue: got wr=%b addr=%0d want 1 11", wr_req, addr); end
      checks++; if (data !== 16'd5) begin errors++; $display("FAIL rmw_write_data: got %h want 0005", data); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (wr_req !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL rmw_req_cleared: got wr=%b rd=%b want 0 0", wr_req, rd_req); end
      checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL rmw_data_released: got %h want ffff (pulled up)", data); end
      checks++; if (pc !== 16'd0 || addr !== 16'd0) begin errors++; $display("FAIL rmw_pc_addr: got pc=%h addr=%h want 0000 0000", pc, addr); end
      @(posedge clk); #1;
      checks++; if (mem[11] !== 16'd7) begin errors++; $display("FAIL rmw_mem_untouched: got %h want 0007", mem[11]); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (rd_req !== 1'b1 || addr !== 16'd0) begin errors++; $display("FAIL rmw_restart: got rd=%b addr=%h want 1 0000", rd_req, addr); end
   endtask

   initial begin
      test_reset();
      test_taken();
      test_not_taken();
      test_self_clear();
      test_halt();
      test_timeout();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
